// File: rtl/serial_adder.sv
// Bit-serial adder: one full adder and a carry flip-flop process one bit per clock, LSB first.
// Optional subtract mode (sub port, a - b) is compiled in when SERIAL_ADDER_SUB_EN is defined.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             sub_sel;
  logic [WIDTH-1:0] b_load;
  logic             c_load;
  logic             sum_bit;
  logic             carry_next;
  logic [WIDTH:0]   res_cat;
  logic [WIDTH-1:0] res_next;
  logic             last_bit;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_sel = sub;
`else
  assign sub_sel = 1'b0;
`endif

  // Subtraction is a + ~b + 1, so only the loaded operand and initial carry differ.
  assign b_load = sub_sel ? ~b : b;
  assign c_load = sub_sel ? 1'b1 : cin;

  assign sum_bit    = a_sh[0] ^ b_sh[0] ^ carry;
  assign carry_next = (a_sh[0] & b_sh[0]) | (b_sh[0] & carry) | (a_sh[0] & carry);

  // New sum bit enters at the MSB; the concatenate-and-shift form also holds for WIDTH=1.
  assign res_cat  = {sum_bit, res_sh} >> 1;
  assign res_next = res_cat[WIDTH-1:0];
  assign last_bit = (cnt == CW'(WIDTH - 1));

  // NOTE: all state below uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would let later lines see half-updated state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b_load;
            carry <= c_load;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= res_next;
          carry  <= carry_next;
          cnt    <= cnt + CW'(1);
          if (last_bit) begin
            // carry still holds the carry into the MSB at this point.
            sum   <= res_next;
            cout  <= carry_next;
            ovf   <= carry ^ carry_next;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Randomised self-checking bench for serial_adder (WIDTH=8 and WIDTH=1 instances) against
// an arithmetic reference model; exercises subtract mode when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder;

`ifdef SERIAL_ADDER_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start8 = 1'b0, cin8 = 1'b0, sub8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] sum8;

  logic       start1 = 1'b0, cin1 = 1'b0, sub1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       busy1, done1, cout1, ovf1;
  logic [0:0] sum1;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub8),
`endif
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub1),
`endif
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] s;
    logic        co;
    logic        ov;
  } res_t;

  // Reference: plain integer addition of the (possibly inverted) operands.
  function automatic res_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input logic sub);
    res_t        r;
    longint      mask, aa, bb, t;
    logic        c;
    mask = (longint'(1) << w) - 1;
    aa   = longint'(a) & mask;
    bb   = (sub && SUB_EN) ? (~longint'(b) & mask) : (longint'(b) & mask);
    c    = (sub && SUB_EN) ? 1'b1 : cin;
    t    = aa + bb + longint'(c);
    r.s  = 32'(t & mask);
    r.co = t[w];
    r.ov = (aa[w-1] == bb[w-1]) && (t[w-1] != aa[w-1]);
    return r;
  endfunction

  res_t prev8 = '{s: 32'd0, co: 1'b0, ov: 1'b0};

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub);
    res_t e;
    int   lat, nbusy;
    e = model(8, {24'd0, a}, {24'd0, b}, cin, sub);
    @(negedge clk);
    a8 = a; b8 = b; cin8 = cin; sub8 = sub; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); sub8 = 1'($urandom);
    check("sum_hold", {56'd0, sum8}, {32'd0, prev8.s});
    lat = -1; nbusy = 0;
    for (int k = 0; k < 20; k++) begin
      if (done8) begin
        lat = k;
        break;
      end
      if (busy8) nbusy++;
      @(negedge clk);
    end
    check("latency", 64'(lat), 64'd8);
    check("busy_cycles", 64'(nbusy), 64'd8);
    check("sum", {56'd0, sum8}, {32'd0, e.s});
    check("cout", {63'd0, cout8}, {63'd0, e.co});
    check("ovf", {63'd0, ovf8}, {63'd0, e.ov});
    prev8 = e;
    @(negedge clk);
    check("done_single", {63'd0, done8}, 64'd0);
  endtask

  task automatic op1(input logic [2:0] v);
    int lat;
    @(negedge clk);
    a1 = v[2]; b1 = v[1]; cin1 = v[0]; sub1 = 1'b0; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; a1 = ~v[2]; b1 = ~v[1]; cin1 = ~v[0];
    lat = -1;
    for (int k = 0; k < 10; k++) begin
      if (done1) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    check("w1_latency", 64'(lat), 64'd1);
    // Full-adder truth table: {cout,sum} is the count of ones among a, b, cin.
    check("w1_result", {62'd0, cout1, sum1}, 64'(v[2] + v[1] + v[0]));
    @(negedge clk);
  endtask

  initial begin
    int cyc, ndone;
    int dt[3];
    int nd;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("rst_busy", {63'd0, busy8}, 64'd0);
    check("rst_done", {63'd0, done8}, 64'd0);
    check("rst_sum", {56'd0, sum8}, 64'd0);
    check("rst_cout_ovf", {62'd0, cout8, ovf8}, 64'd0);

    op8(8'hFF, 8'h01, 1'b0, 1'b0);
    check("v1_sum", {56'd0, sum8}, 64'h00);
    check("v1_cout_ovf", {62'd0, cout8, ovf8}, 64'b10);
    op8(8'h7F, 8'h01, 1'b0, 1'b0);
    check("v2_sum", {56'd0, sum8}, 64'h80);
    check("v2_cout_ovf", {62'd0, cout8, ovf8}, 64'b01);
    op8(8'h80, 8'h80, 1'b0, 1'b0);
    check("v3_sum", {56'd0, sum8}, 64'h00);
    check("v3_cout_ovf", {62'd0, cout8, ovf8}, 64'b11);

    // A second start three clocks into RUN must be dropped.
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      if (k == 3) begin
        a8 = 8'hA0; b8 = 8'h0B; start8 = 1'b1;
      end else begin
        start8 = 1'b0;
      end
      @(negedge clk);
      if (done8) ndone++;
    end
    check("repulse_dones", 64'(ndone), 64'd1);
    check("repulse_sum", {56'd0, sum8}, 64'h46);
    prev8 = model(8, 32'h12, 32'h34, 1'b0, 1'b0);

    // Reset at clock 4 of RUN aborts; start asserted on the reset edge is ignored.
    @(negedge clk);
    a8 = 8'h55; b8 = 8'h22; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0; start8 = 1'b1;
    @(negedge clk);
    rst_n = 1'b1; start8 = 1'b0;
    check("abort_busy_done", {62'd0, busy8, done8}, 64'd0);
    check("abort_sum", {56'd0, sum8}, 64'd0);
    check("abort_cout_ovf", {62'd0, cout8, ovf8}, 64'd0);
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done8 || busy8) ndone++;
    end
    check("abort_no_activity", 64'(ndone), 64'd0);
    prev8 = '{s: 32'd0, co: 1'b0, ov: 1'b0};
    op8(8'd3, 8'd4, 1'b0, 1'b0);
    check("after_abort_sum", {56'd0, sum8}, 64'd7);

    // Continuous start: one result every WIDTH+2 clocks.
    @(negedge clk);
    a8 = 8'h3C; b8 = 8'h5A; cin8 = 1'b1; sub8 = 1'b0; start8 = 1'b1;
    nd = 0;
    for (cyc = 0; cyc < 40 && nd < 3; cyc++) begin
      @(negedge clk);
      if (done8) begin
        dt[nd] = cyc;
        nd++;
      end
    end
    start8 = 1'b0;
    check("b2b_count", 64'(nd), 64'd3);
    if (nd == 3) begin
      check("b2b_period0", 64'(dt[1] - dt[0]), 64'd10);
      check("b2b_period1", 64'(dt[2] - dt[1]), 64'd10);
    end
    check("b2b_sum", {56'd0, sum8}, 64'h97);
    repeat (12) @(negedge clk);
    prev8 = model(8, 32'h3C, 32'h5A, 1'b1, 1'b0);

    if (SUB_EN) begin
      op8(8'h05, 8'h07, 1'b0, 1'b1);
      check("sub1_sum_cout", {55'd0, sum8, cout8}, {55'd0, 8'hFE, 1'b0});
      op8(8'h07, 8'h05, 1'b1, 1'b1);
      check("sub2_sum_cout", {55'd0, sum8, cout8}, {55'd0, 8'h02, 1'b1});
    end

    for (int i = 0; i < 40; i++)
      op8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));

    for (int i = 0; i < 8; i++)
      op1(3'(i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
